hilo_unit: RTL and testbench

Holds the architectural HI/LO register pair and performs the multi-cycle DIV/DIVU operation. It sits beside the ALU in the execute stage. It supplies `hi`/`lo` to the ALU for MADD/MADDU accumulation and MFHI/MFLO reads. It commits the ALU's 64-bit `mul_result` on MULT/MADD/MADDU, and it asserts `busy` so the pipeline stalls while a divide is in flight.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/hilo_unit_div_step.sv | 26 ++
 rtl/hilo_unit.sv | 157 +++++++++++++++
 tb/tb_hilo_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared HI/LO definitions: divider FSM states, step count and the HI/LO
// write-select encoding that the control unit also uses.
package mips_pkg;

  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } hilo_state_e;

  typedef enum logic [1:0] {
    WSEL_NONE = 2'd0,
    WSEL_MT   = 2'd1,
    WSEL_MUL  = 2'd2,
    WSEL_DIV  = 2'd3
  } hilo_wsel_e;

endpackage

// File: rtl/hilo_unit_div_step.sv
// One restoring-division step on {rem,quo}: shift left, then trial-subtract
// the divisor and keep the difference when it does not go negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          fits;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    // Sign of the XLEN+1-bit difference is the rem < divisor indicator
    trial   = shifted - {1'b0, dvsr_i};
    fits    = ~trial[XLEN];
    rem_o   = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with prioritised MT/MUL writes and a 32-step
// restoring DIV/DIVU engine that stalls the pipeline through busy.
module hilo_unit
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_div,
  input  logic              div_unsigned,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              mul_we,
  input  logic [2*XLEN-1:0] mul_result,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   lo,
  output logic              busy,
  output logic              div_done,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DIV_STEPS);

  hilo_state_e      state_q, state_d;
  hilo_wsel_e       wsel;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d, skip_q, skip_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic [XLEN-1:0]  step_rem, step_quo;
  logic             a_neg, b_neg;

  function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      skip_q  <= skip_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_div) state_d = (b == '0) ? ST_FIX : ST_DIV;
      ST_DIV:  if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    negq_d = negq_q;
    negr_d = negr_q;
    skip_d = skip_q;
    done_d = 1'b0;
    dbz_d  = 1'b0;
    a_neg  = a[XLEN-1] & ~div_unsigned;
    b_neg  = b[XLEN-1] & ~div_unsigned;

    wsel = WSEL_NONE;
    if (state_q == ST_IDLE) begin
      if (start_div)          wsel = WSEL_DIV;
      else if (mul_we)        wsel = WSEL_MUL;
      else if (mthi || mtlo)  wsel = WSEL_MT;
    end

    case (wsel)
      WSEL_DIV: begin
        quo_d  = a_neg ? neg2(a) : a;
        dvsr_d = b_neg ? neg2(b) : b;
        rem_d  = '0;
        cnt_d  = '0;
        negq_d = a_neg ^ b_neg;
        negr_d = a_neg;
        skip_d = (b == '0);
      end
      WSEL_MUL: {hi_d, lo_d} = mul_result;
      WSEL_MT: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
      end
      default: ;
    endcase

    case (state_q)
      ST_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
      end
      ST_FIX: begin
        // A zero divisor reaches FIX without computing anything, so HI/LO hold
        if (!skip_q) begin
          lo_d = negq_q ? neg2(quo_q) : quo_q;
          hi_d = negr_q ? neg2(rem_q) : rem_q;
        end
        done_d = 1'b1;
        dbz_d  = skip_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    div_done    = done_q;
    div_by_zero = dbz_q;
    hi          = hi_q;
    lo          = lo_q;
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: write priority, DIV/DIVU results, divide by
// zero, asynchronous abort and writes ignored while busy.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_div = 1'b0, div_unsigned = 1'b0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        mul_we = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [63:0] mul_result = '0;
  logic [31:0] hi, lo;
  logic        busy, div_done, div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  hilo_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_div(start_div), .div_unsigned(div_unsigned),
    .a(a), .b(b), .mul_we(mul_we), .mul_result(mul_result),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .div_done(div_done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic uns);
    a = av; b = bv; div_unsigned = uns; start_div = 1'b1;
    tick();
    start_div = 1'b0;
  endtask

  task automatic wait_done(output int bc, output logic dz);
    logic seen;
    bc = 0; dz = 1'b0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (div_done) begin
        seen = 1'b1;
        dz = div_by_zero;
        break;
      end
      if (busy) bc++;
      tick();
    end
    check("div_done_seen", {63'd0, seen}, 64'd1);
  endtask

  int   bc;
  logic dz;

  initial begin
    #2;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, div_done}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // MTHI then MTLO, one cycle latency each
    mthi = 1'b1; wdata = 32'h12345678;
    check("mthi_pre", {32'd0, hi}, 64'd0);
    tick();
    mthi = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h12345678);
    mtlo = 1'b1; wdata = 32'h9ABCDEF0;
    tick();
    mtlo = 1'b0;
    check("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
    check("mtlo_hi_kept", {32'd0, hi}, 64'h12345678);

    // Divide beats a simultaneous multiply write
    mul_we = 1'b1; mul_result = 64'h00000001_FFFFFFFE;
    start_op(32'd7, 32'd2, 1'b1);
    mul_we = 1'b0;
    check("mul_dropped", {hi, lo}, 64'h12345678_9ABCDEF0);
    wait_done(bc, dz);
    check("divu7_2_busy_cycles", 64'(bc), 64'd33);
    check("divu7_2_lo", {32'd0, lo}, 64'd3);
    check("divu7_2_hi", {32'd0, hi}, 64'd1);
    check("divu7_2_dbz", {63'd0, dz}, 64'd0);
    check("divu7_2_busy_at_done", {63'd0, busy}, 64'd0);
    tick();
    check("divu7_2_done_single", {63'd0, div_done}, 64'd0);

    // Signed: remainder follows the dividend sign
    start_op(32'hFFFFFFF9, 32'd2, 1'b0);
    wait_done(bc, dz);
    check("div_m7_2_lo", {32'd0, lo}, 64'hFFFFFFFD);
    check("div_m7_2_hi", {32'd0, hi}, 64'hFFFFFFFF);
    tick();
    start_op(32'd7, 32'hFFFFFFFE, 1'b0);
    wait_done(bc, dz);
    check("div_7_m2_lo", {32'd0, lo}, 64'hFFFFFFFD);
    check("div_7_m2_hi", {32'd0, hi}, 64'd1);
    tick();

    // Signed overflow wraps silently
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_done(bc, dz);
    check("div_ovf_lo", {32'd0, lo}, 64'h80000000);
    check("div_ovf_hi", {32'd0, hi}, 64'd0);
    check("div_ovf_dbz", {63'd0, dz}, 64'd0);
    tick();

    // Divide by zero: one busy cycle, HI/LO untouched
    start_op(32'd55, 32'd0, 1'b1);
    wait_done(bc, dz);
    check("dbz_busy_cycles", 64'(bc), 64'd1);
    check("dbz_flag", {63'd0, dz}, 64'd1);
    check("dbz_hilo_kept", {hi, lo}, 64'h00000000_80000000);
    tick();
    check("dbz_pulse_end", {62'd0, div_done, div_by_zero}, 64'd0);

    // Asynchronous reset at step 15 aborts the divide
    start_op(32'd1000, 32'd3, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_done", {63'd0, div_done}, 64'd0);
    tick();
    rst = 1'b0;
    bc = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (div_done || busy) bc++;
    end
    check("abort_no_done", 64'(bc), 64'd0);
    start_op(32'd100, 32'd7, 1'b1);
    wait_done(bc, dz);
    check("divu100_7_lo", {32'd0, lo}, 64'd14);
    check("divu100_7_hi", {32'd0, hi}, 64'd2);
    tick();

    // Writes and new starts ignored while busy
    start_op(32'd100, 32'd7, 1'b1);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
    mul_we = 1'b1; mul_result = 64'hCAFEF00D_0BADC0DE;
    start_div = 1'b1; a = 32'd9; b = 32'd0;
    tick(); tick(); tick();
    check("busy_writes_ignored", {hi, lo}, 64'h00000002_0000000E);
    mthi = 1'b0; mtlo = 1'b0; mul_we = 1'b0; start_div = 1'b0;
    wait_done(bc, dz);
    check("busy_div_lo", {32'd0, lo}, 64'd14);
    check("busy_div_hi", {32'd0, hi}, 64'd2);
    check("busy_div_dbz", {63'd0, dz}, 64'd0);
    tick();
    check("busy_after_idle", {62'd0, busy, div_done}, 64'd0);

    // MADD-style accumulate commits exactly
    mul_we = 1'b1; mul_result = {hi, lo} + 64'd6;
    tick();
    mul_we = 1'b0;
    check("madd_commit", {hi, lo}, 64'h00000002_00000014);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
